regfile_scoreboard: RTL and testbench

- Architectural register file that consumes the write-back stage result (selected ALU or memory data) and services decode-stage reads.
- 8 x 16-bit registers, one synchronous write port and two combinational read ports, with write-through bypass.
- Per-register pending-write scoreboard: decode allocates destinations, write-back retires them, and the block raises stall on RAW hazards.

---
 rtl/regfile_scoreboard_pkg.sv | 9 +
 rtl/regfile_scoreboard_pending_counter.sv | 34 +++
 rtl/regfile_scoreboard.sv | 84 ++++++++
 tb/tb_regfile_scoreboard.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants for the register file and its pending-write scoreboard.
package regfile_scoreboard_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
endpackage

// File: rtl/regfile_scoreboard_pending_counter.sv
// One register's count of in-flight writes: issue increments, write-back decrements.
module pending_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 busy
);

  logic dec_eff;

  // A retire against an empty counter is a stray write and must not underflow.
  always_comb begin
    busy    = (cnt != '0);
    dec_eff = dec & busy;
  end

  // Counter state; simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec_eff) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec_eff && !inc) begin
      cnt <= cnt - CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 8x16 register file with write-through bypass and a per-register RAW scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbEnable,
  input  logic [ADDR_WIDTH-1:0] wbAddr,
  input  logic [DATA_WIDTH-1:0] wbData,
  input  logic [ADDR_WIDTH-1:0] rdAddr1,
  input  logic [ADDR_WIDTH-1:0] rdAddr2,
  input  logic                  rdUse1,
  input  logic                  rdUse2,
  input  logic                  issueValid,
  input  logic                  issueWrites,
  input  logic [ADDR_WIDTH-1:0] issueDest,
  output logic [DATA_WIDTH-1:0] rdData1,
  output logic [DATA_WIDTH-1:0] rdData2,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busyVec
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   inc;
  logic [NUM_REGS-1:0]   dec;
  logic                  haz1;
  logic                  haz2;
  logic                  sat;
  logic                  acc;

  // Register storage; the write-back commit is unconditional on scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wbEnable) begin
      regs[wbAddr] <= wbData;
    end
  end

  // Read ports with bypass from the concurrent write-back.
  always_comb begin
    rdData1 = '0;
    rdData2 = '0;
    if (!rst) begin
      rdData1 = '0;
      rdData2 = '0;
    end else begin
      rdData1 = (wbEnable && (wbAddr == rdAddr1)) ? wbData : regs[rdAddr1];
      rdData2 = (wbEnable && (wbAddr == rdAddr2)) ? wbData : regs[rdAddr2];
    end
  end

  // Hazard and saturation detection; a source whose last pending write retires now is served by bypass.
  always_comb begin
    haz1 = rdUse1 && (cnt[rdAddr1] != '0) &&
           !(wbEnable && (wbAddr == rdAddr1) && (cnt[rdAddr1] == CNT_ONE));
    haz2 = rdUse2 && (cnt[rdAddr2] != '0) &&
           !(wbEnable && (wbAddr == rdAddr2) && (cnt[rdAddr2] == CNT_ONE));
    sat  = issueValid && issueWrites && (cnt[issueDest] == CNT_MAX);
    stall = rst && (haz1 || haz2 || sat);
    acc   = rst && issueValid && issueWrites && !stall;
    busyVec = rst ? busy : '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = acc && (issueDest == ADDR_WIDTH'(i));
      dec[i] = wbEnable && (wbAddr == ADDR_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    pending_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[g]),
      .dec  (dec[g]),
      .cnt  (cnt[g]),
      .busy (busy[g])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random stimulus against an array/counter model of the register file scoreboard.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        wbEnable;
  logic [2:0]  wbAddr;
  logic [15:0] wbData;
  logic [2:0]  rdAddr1, rdAddr2;
  logic        rdUse1, rdUse2;
  logic        issueValid, issueWrites;
  logic [2:0]  issueDest;
  logic [15:0] rdData1, rdData2;
  logic        stall;
  logic [7:0]  busyVec;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  int          m_cnt  [8];

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdUse1(rdUse1), .rdUse2(rdUse2),
    .issueValid(issueValid), .issueWrites(issueWrites), .issueDest(issueDest),
    .rdData1(rdData1), .rdData2(rdData2), .stall(stall), .busyVec(busyVec)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input bit we, input int wa, input int wd,
                        input int a1, input int a2, input bit u1, input bit u2,
                        input bit iv, input bit iw, input int d);
    rst = r; wbEnable = we; wbAddr = 3'(wa); wbData = 16'(wd);
    rdAddr1 = 3'(a1); rdAddr2 = 3'(a2); rdUse1 = u1; rdUse2 = u2;
    issueValid = iv; issueWrites = iw; issueDest = 3'(d);
  endtask

  // Compare outputs with the model for the held inputs, clock once, then advance the model.
  task automatic step();
    logic [15:0] e1, e2;
    logic [7:0]  eb;
    bit h1, h2, es, acc, dec;
    #1;
    e1 = 16'h0; e2 = 16'h0; eb = 8'h0; es = 1'b0; acc = 1'b0;
    if (rst) begin
      e1 = (wbEnable && wbAddr == rdAddr1) ? wbData : m_regs[rdAddr1];
      e2 = (wbEnable && wbAddr == rdAddr2) ? wbData : m_regs[rdAddr2];
      h1 = rdUse1 && m_cnt[rdAddr1] > 0 && !(wbEnable && wbAddr == rdAddr1 && m_cnt[rdAddr1] == 1);
      h2 = rdUse2 && m_cnt[rdAddr2] > 0 && !(wbEnable && wbAddr == rdAddr2 && m_cnt[rdAddr2] == 1);
      es = h1 || h2 || (issueValid && issueWrites && m_cnt[issueDest] == 3);
      acc = issueValid && issueWrites && !es;
      for (int i = 0; i < 8; i++) eb[i] = (m_cnt[i] != 0);
    end
    check_value("rdData1", rdData1, e1);
    check_value("rdData2", rdData2, e2);
    check_value("stall", stall, es);
    check_value("busyVec", busyVec, eb);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 16'h0; m_cnt[i] = 0; end
    end else begin
      dec = wbEnable && m_cnt[wbAddr] != 0;
      if (wbEnable) m_regs[wbAddr] = wbData;
      if (acc) m_cnt[issueDest]++;
      if (dec) m_cnt[wbAddr]--;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_regs[i] = 16'h0; m_cnt[i] = 0; end
    // Reset then read
    set_in(0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0); #1;
    check_value("reset_rd1", rdData1, 16'h0);
    check_value("reset_rd2", rdData2, 16'h0);
    check_value("reset_busy", busyVec, 8'h0);
    check_value("reset_stall", stall, 1'b0);
    step();
    // Write with bypass, then readback
    set_in(1, 1, 2, 16'hBEEF, 2, 0, 0, 0, 0, 0, 0); #1;
    check_value("bypass_rd1", rdData1, 16'hBEEF); step();
    set_in(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0); #1;
    check_value("readback_rd1", rdData1, 16'hBEEF); step();
    // RAW stall and release
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4); step();
    check_value("busy4_set", busyVec[4], 1'b1);
    set_in(1, 0, 0, 0, 4, 0, 1, 0, 1, 1, 5); #1;
    check_value("raw_stall", stall, 1'b1); step();
    check_value("ignored_issue5", busyVec[5], 1'b0);
    set_in(1, 1, 4, 16'h0042, 4, 0, 1, 0, 0, 0, 0); #1;
    check_value("release_stall", stall, 1'b0);
    check_value("release_rd1", rdData1, 16'h0042); step();
    set_in(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0); #1;
    check_value("busy4_clear", busyVec[4], 1'b0); step();
    // Three in-flight writes to r1, fourth saturates
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); #1;
    check_value("sat_stall", stall, 1'b1); step();
    set_in(1, 1, 1, 16'h1111, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0); #1;
    check_value("busy1_after_one_wb", busyVec[1], 1'b1);
    check_value("r1_still_stalls", stall, 1'b1); step();
    for (int k = 0; k < 2; k++) begin
      set_in(1, 1, 1, 16'h2222 + k, 0, 0, 0, 0, 0, 0, 0); step();
    end
    // Simultaneous issue and retire on r6
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6); step();
    set_in(1, 1, 6, 16'h1234, 0, 0, 0, 0, 1, 1, 6); step();
    set_in(1, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0); #1;
    check_value("r6_still_pending", stall, 1'b1);
    check_value("r6_written", rdData1, 16'h1234); step();
    // Reset mid-operation
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3); step();
    set_in(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0); #1;
    check_value("midrst_busy", busyVec, 8'h0);
    check_value("midrst_rd6", rdData2, 16'h0); step();
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 65535), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 7));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
